// File: rtl/gray2bin_pipe.sv
// Pipelined Gray<->binary converter with valid/ready handshakes on both sides.
// The MSB-first prefix-XOR chain of a Gray->binary decode is split across
// STAGES register stages; binary->Gray is a single XOR done in stage 0 and the
// result is carried unchanged so both directions share the same latency.
module gray2bin_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
);

  // Bits resolved per stage, MSB first; the last stage takes whatever is left.
  localparam int unsigned CHUNK = (WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_mode;
  logic [WIDTH-1:0]  stg_data [STAGES];
  logic [STAGES-1:0] stg_load;

  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_mode;
  logic [WIDTH-1:0]  src_data [STAGES];

  // Resolve the Gray bits owned by stage k; bits above are already binary,
  // bits below are still Gray and pass through untouched.
  function automatic logic [WIDTH-1:0] resolve_chunk(input logic [WIDTH-1:0] d,
                                                     input int k);
    logic [WIDTH-1:0] r;
    r = d;
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      if ((int'(WIDTH) - 1 - i) / int'(CHUNK) == k) begin
        r[i] = r[i+1] ^ d[i];
      end
    end
    return r;
  endfunction

  // Next contents offered to each stage from its upstream neighbour.
  always_comb begin
    src_valid = '0;
    src_mode  = '0;
    src_data  = '{default: '0};
    src_valid[0] = in_valid;
    src_mode[0]  = in_mode;
    src_data[0]  = in_mode ? (in_data ^ (in_data >> 1)) : resolve_chunk(in_data, 0);
    for (int k = 1; k < int'(STAGES); k++) begin
      src_valid[k] = stg_valid[k-1];
      src_mode[k]  = stg_mode[k-1];
      src_data[k]  = stg_mode[k-1] ? stg_data[k-1] : resolve_chunk(stg_data[k-1], k);
    end
  end

  // Load enables ripple back from the output: a stage loads when it is empty
  // or its successor is loading, so internal bubbles collapse under a stall.
  always_comb begin : p_load
    logic ld;
    stg_load = '0;
    ld       = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ld          = !stg_valid[k] || ld;
      stg_load[k] = ld;
    end
  end

  // Stage registers; reset discards every in-flight beat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= '0;
      stg_mode  <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        stg_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (stg_load[k]) begin
          stg_valid[k] <= src_valid[k];
          stg_mode[k]  <= src_mode[k];
          stg_data[k]  <= src_data[k];
        end
      end
    end
  end

  assign in_ready  = stg_load[0];
  assign out_valid = stg_valid[STAGES-1];
  assign out_mode  = stg_mode[STAGES-1];
  assign out_data  = stg_data[STAGES-1];

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Self-checking bench for gray2bin_pipe: table-driven streams, backpressure,
// reset and corner configurations, plus a randomized scoreboarded run.
module tb_gray2bin_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_chk  = 0;
  int n_fail = 0;

  // DUT A: WIDTH=4, STAGES=2
  logic       a_iv, a_ir, a_im, a_ov, a_or, a_om;
  logic [3:0] a_id, a_od;
  gray2bin_pipe #(.WIDTH(4), .STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_mode(a_im),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_mode(a_om), .out_data(a_od));

  // DUT B: WIDTH=8, STAGES=3
  logic       b_iv, b_ir, b_im, b_ov, b_or, b_om;
  logic [7:0] b_id, b_od;
  gray2bin_pipe #(.WIDTH(8), .STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_im),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_mode(b_om), .out_data(b_od));

  // DUT C: WIDTH=1, STAGES=1
  logic       c_iv, c_ir, c_im, c_ov, c_or, c_om;
  logic [0:0] c_id, c_od;
  gray2bin_pipe #(.WIDTH(1), .STAGES(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_mode(c_im),
    .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_mode(c_om), .out_data(c_od));

  // DUT D: WIDTH=16, STAGES=16
  logic        d_iv, d_ir, d_im, d_ov, d_or, d_om;
  logic [15:0] d_id, d_od;
  gray2bin_pipe #(.WIDTH(16), .STAGES(16)) dut_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_mode(d_im),
    .in_data(d_id), .out_valid(d_ov), .out_ready(d_or), .out_mode(d_om), .out_data(d_od));

  typedef struct {
    logic       m;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  typedef struct packed {
    logic       m;
    logic [3:0] d;
  } a_exp_t;

  typedef struct packed {
    logic       m;
    logic [7:0] din;
    logic [7:0] exp;
  } b_exp_t;

  vec_t       vt[20];
  a_exp_t     a_q[$];
  a_exp_t     a_e;
  b_exp_t     b_q[$];
  logic [3:0] bp_din[4];
  logic [3:0] bp_exp[4];

  // Reference: binary bit i is the parity of all Gray bits at or above i.
  function automatic logic [31:0] ref_g2b(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [31:0] ref_b2g(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] ref_conv(input logic m, input logic [31:0] d);
    return m ? ref_b2g(d) : ref_g2b(d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor for DUT A: every delivered beat must match the queue head.
  always @(negedge clk) begin
    #1;
    if (!rst && a_ov && a_or) begin
      if (a_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_extra_beat: actual %0h with no beat outstanding at %0t", a_od, $time);
      end else begin
        a_e = a_q.pop_front();
        chk("a_out_beat", 32'({a_om, a_od}), 32'({a_e.m, a_e.d}));
      end
    end
  end

  // Offer one beat on A until accepted (bounded).
  task automatic a_send(input logic m, input logic [3:0] din, input logic [3:0] exp);
    int   c;
    logic done;
    c    = 0;
    done = 1'b0;
    while (!done && c < 50) begin
      @(negedge clk);
      a_iv = 1'b1;
      a_im = m;
      a_id = din;
      #1;
      if (a_ir) begin
        a_q.push_back('{m: m, d: exp});
        done = 1'b1;
      end
      c++;
    end
    chk("a_send_accepted", 32'(done), 32'(1));
  endtask

  // Stop offering and wait (bounded) for all outstanding A beats to emerge.
  task automatic a_drain(input string name);
    int c;
    c = 0;
    @(negedge clk);
    a_iv = 1'b0;
    while (a_q.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    #2;
    chk(name, 32'(a_q.size()), 32'(0));
  endtask

  // Stream the vector table back-to-back with out_ready held high.
  task automatic a_stream(input int n);
    int idx, cyc, outs, first_acc, first_out, last_out;
    idx = 0; cyc = 0; outs = 0; first_acc = -1; first_out = -1; last_out = -1;
    a_or = 1'b1;
    while ((idx < n || a_q.size() != 0) && cyc < 200) begin
      @(negedge clk);
      a_iv = (idx < n);
      if (idx < n) begin
        a_im = vt[idx].m;
        a_id = vt[idx].din;
      end
      #1;
      if (a_ov) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        outs++;
      end
      if (a_iv && a_ir) begin
        a_q.push_back('{m: vt[idx].m, d: vt[idx].exp});
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      cyc++;
    end
    a_iv = 1'b0;
    chk("a_stream_done", 32'(a_q.size()), 32'(0));
    chk("a_latency", 32'(first_out - first_acc), 32'(2));
    chk("a_throughput", 32'(last_out - first_out), 32'(n - 1));
    chk("a_out_count", 32'(outs), 32'(n));
  endtask

  // Random valid/ready on B with a queue scoreboard and occupancy model.
  task automatic b_random();
    int     sent, rcvd, cyc, occ;
    logic   prev_stall, prev_m;
    logic [7:0] prev_d;
    b_exp_t e;
    sent = 0; rcvd = 0; cyc = 0;
    prev_stall = 1'b0; prev_m = 1'b0; prev_d = '0;
    while (rcvd < 1000 && cyc < 20000) begin
      @(negedge clk);
      b_iv = (sent < 1000) && ($urandom_range(0, 1) == 1);
      b_im = ($urandom_range(0, 1) == 1);
      b_id = 8'($urandom);
      b_or = ($urandom_range(0, 1) == 1);
      #1;
      occ = b_q.size();
      if (b_or) chk("b_ready_flow", 32'(b_ir), 32'(1));
      else if (occ < 3) chk("b_ready_not_full", 32'(b_ir), 32'(1));
      else chk("b_ready_full", 32'(b_ir), 32'(0));
      if (prev_stall) begin
        chk("b_stall_valid", 32'(b_ov), 32'(1));
        chk("b_stall_hold", 32'({b_om, b_od}), 32'({prev_m, prev_d}));
      end
      if (b_iv && b_ir) begin
        b_q.push_back('{m: b_im, din: b_id, exp: 8'(ref_conv(b_im, 32'(b_id)))});
        sent++;
      end
      if (b_ov && b_or) begin
        if (b_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL b_extra_beat: actual %0h with no beat outstanding at %0t", b_od, $time);
        end else begin
          e = b_q.pop_front();
          chk("b_data", 32'(b_od), 32'(e.exp));
          chk("b_mode", 32'(b_om), 32'(e.m));
          if (e.m) chk("b_roundtrip", ref_g2b(32'(b_od)), 32'(e.din));
        end
        rcvd++;
      end
      prev_stall = b_ov && !b_or;
      prev_m     = b_om;
      prev_d     = b_od;
      cyc++;
    end
    b_iv = 1'b0;
    b_or = 1'b1;
    chk("b_received", 32'(rcvd), 32'(1000));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Gray codes for 0..15 in sequence, then mode-1 and alternating-mode beats.
    logic [3:0] gseq[16];
    int idx;
    gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    for (int i = 0; i < 16; i++) vt[i] = '{m: 1'b0, din: gseq[i], exp: 4'(i)};
    vt[16] = '{m: 1'b1, din: 4'b1010, exp: 4'b1111};
    vt[17] = '{m: 1'b1, din: 4'b0111, exp: 4'b0100};
    vt[18] = '{m: 1'b0, din: 4'b0110, exp: 4'b0100};
    vt[19] = '{m: 1'b1, din: 4'b0110, exp: 4'b0101};
    bp_din = '{4'h1, 4'h3, 4'h2, 4'h6};
    bp_exp = '{4'h1, 4'h2, 4'h3, 4'h4};

    rst = 1'b1;
    a_iv = 0; a_im = 0; a_id = '0; a_or = 0;
    b_iv = 0; b_im = 0; b_id = '0; b_or = 0;
    c_iv = 0; c_im = 0; c_id = '0; c_or = 0;
    d_iv = 0; d_im = 0; d_id = '0; d_or = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_out_valid", 32'(a_ov), 32'(0));
    chk("rst_a_out_data", 32'(a_od), 32'(0));
    chk("rst_a_out_mode", 32'(a_om), 32'(0));
    chk("rst_a_in_ready", 32'(a_ir), 32'(1));
    chk("rst_b_out_valid", 32'(b_ov), 32'(0));
    chk("rst_d_out_data", 32'(d_od), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 32'(a_ir), 32'(1));
    chk("post_rst_out_valid", 32'(a_ov), 32'(0));

    // Full-rate streams, both modes, alternating modes back to back.
    a_stream(20);

    // Backpressure: only two beats fit, output holds, ready returns with out_ready.
    a_or = 1'b0;
    idx  = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      a_iv = 1'b1;
      a_im = 1'b0;
      a_id = bp_din[idx];
      #1;
      if (c >= 2) begin
        chk("bp_hold_valid", 32'(a_ov), 32'(1));
        chk("bp_hold_data", 32'({a_om, a_od}), 32'({1'b0, 4'h1}));
      end
      if (a_ir) begin
        a_q.push_back('{m: 1'b0, d: bp_exp[idx]});
        idx++;
      end
    end
    chk("bp_accepted", 32'(idx), 32'(2));
    chk("bp_in_ready_low", 32'(a_ir), 32'(0));
    @(negedge clk);
    a_or = 1'b1;
    a_id = bp_din[idx];
    #1;
    chk("bp_ready_same_cycle", 32'(a_ir), 32'(1));
    if (a_ir) begin
      a_q.push_back('{m: 1'b0, d: bp_exp[idx]});
      idx++;
    end
    while (idx < 4) begin
      a_send(1'b0, bp_din[idx], bp_exp[idx]);
      idx++;
    end
    a_drain("bp_drain");

    // Reset with two beats in flight.
    a_or = 1'b0;
    a_send(1'b0, 4'h7, 4'h5);
    a_send(1'b1, 4'h3, 4'h2);
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    chk("rst_mid_pre_valid", 32'(a_ov), 32'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_async_drop", 32'(a_ov), 32'(0));
    chk("rst_mid_in_ready", 32'(a_ir), 32'(1));
    a_q.delete();
    @(negedge clk);
    rst  = 1'b0;
    a_or = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("rst_mid_no_ghost", 32'(a_ov), 32'(0));
    end
    a_send(1'b0, 4'hB, 4'hD);
    a_drain("rst_mid_next_beat");

    // WIDTH=1, STAGES=1: one cycle latency.
    @(negedge clk);
    c_or = 1'b1; c_iv = 1'b1; c_im = 1'b0; c_id = 1'b1;
    #1;
    chk("c_in_ready", 32'(c_ir), 32'(1));
    @(negedge clk);
    c_im = 1'b1; c_id = 1'b1;
    #1;
    chk("c_gray1", 32'({c_ov, c_om, c_od}), 32'({1'b1, 1'b0, 1'b1}));
    @(negedge clk);
    c_im = 1'b0; c_id = 1'b0;
    #1;
    chk("c_bin1", 32'({c_ov, c_om, c_od}), 32'({1'b1, 1'b1, 1'b1}));
    @(negedge clk);
    c_iv = 1'b0;
    #1;
    chk("c_gray0", 32'({c_ov, c_om, c_od}), 32'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    #1;
    chk("c_idle", 32'(c_ov), 32'(0));

    // WIDTH=16, STAGES=16: latency 16, back-to-back mixed modes.
    @(negedge clk);
    d_or = 1'b1; d_iv = 1'b1; d_im = 1'b0; d_id = 16'h8000;
    #1;
    chk("d_in_ready", 32'(d_ir), 32'(1));
    @(negedge clk);
    d_im = 1'b1; d_id = 16'h1234;
    for (int k = 1; k <= 18; k++) begin
      if (k > 1) begin
        @(negedge clk);
        d_iv = 1'b0;
      end
      #1;
      chk("d_latency_valid", 32'(d_ov), 32'((k == 16 || k == 17) ? 1 : 0));
      if (k == 16) chk("d_gray8000", 32'({d_om, d_od}), 32'({1'b0, 16'hFFFF}));
      if (k == 17) chk("d_bin1234", 32'({d_om, d_od}), 32'({1'b1, 16'(ref_b2g(32'h1234))}));
    end

    // Randomized run on WIDTH=8, STAGES=3.
    b_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
